// File: rtl/voice_scheduler_if.sv
// Config and waveshaper bus of the voice scheduler.
//   cfg_we/cfg_voice/cfg_divisor/cfg_mode/cfg_en : per-voice config write from the note front end
//   ws_count/ws_divisor/ws_mode                   : current-slot voice presented to the waveshaper
//   ws_sample                                     : waveshaper result for the presented voice
// master = front end + waveshaper side, slave = scheduler side.
interface voice_scheduler_if #(
  parameter int NVOICES = 4,
  parameter int CNT_W   = 19,
  parameter int SMP_W   = 8
);
  logic                       cfg_we;
  logic [$clog2(NVOICES)-1:0] cfg_voice;
  logic [CNT_W-1:0]           cfg_divisor;
  logic [2:0]                 cfg_mode;
  logic                       cfg_en;
  logic [CNT_W-1:0]           ws_count;
  logic [CNT_W-1:0]           ws_divisor;
  logic [2:0]                 ws_mode;
  logic [SMP_W-1:0]           ws_sample;

  modport master (
    output cfg_we, cfg_voice, cfg_divisor, cfg_mode, cfg_en, ws_sample,
    input  ws_count, ws_divisor, ws_mode
  );

  modport slave (
    input  cfg_we, cfg_voice, cfg_divisor, cfg_mode, cfg_en, ws_sample,
    output ws_count, ws_divisor, ws_mode
  );
endinterface

// File: rtl/voice_scheduler.sv
// Time-multiplexes one combinational waveshaper across NVOICES voices.
// Owns per-voice phase counters and config, presents one voice per clock,
// and sums the returned samples of enabled voices into one mix per frame.
//   clk         : system clock
//   Rst_i       : asynchronous active-low reset
//   bus         : config write port and waveshaper presentation (slave side)
//   slot_o      : current slot / presented voice index
//   mix_o       : registered sum of enabled voice samples of the last frame
//   mix_valid_o : one-cycle pulse when mix_o updates
module voice_scheduler #(
  parameter int NVOICES = 4,
  parameter int CNT_W   = 19,
  parameter int SMP_W   = 8,
  parameter int MIX_W   = SMP_W + $clog2(NVOICES)
) (
  input  logic                       clk,
  input  logic                       Rst_i,
  voice_scheduler_if.slave           bus,
  output logic [$clog2(NVOICES)-1:0] slot_o,
  output logic [MIX_W-1:0]           mix_o,
  output logic                       mix_valid_o
);
  localparam int SW = $clog2(NVOICES);
  localparam logic [SW-1:0] LAST = SW'(NVOICES - 1);

  logic [CNT_W-1:0] count   [NVOICES];
  logic [CNT_W-1:0] divisor [NVOICES];
  logic [2:0]       mode    [NVOICES];
  logic             en      [NVOICES];
  logic [MIX_W-1:0] acc;
  logic [MIX_W-1:0] add;

  // Phase counters and config registers. A write retriggers the phase,
  // taking priority over the hold/wrap/increment rule.
  always_ff @(posedge clk or negedge Rst_i) begin
    if (!Rst_i) begin
      for (int unsigned v = 0; v < NVOICES; v++) begin
        count[v]   <= '0;
        divisor[v] <= '0;
        mode[v]    <= '0;
        en[v]      <= 1'b0;
      end
    end else begin
      for (int unsigned v = 0; v < NVOICES; v++) begin
        if (bus.cfg_we && bus.cfg_voice == SW'(v)) begin
          divisor[v] <= bus.cfg_divisor;
          mode[v]    <= bus.cfg_mode;
          en[v]      <= bus.cfg_en;
          count[v]   <= '0;
        end else if (divisor[v] <= CNT_W'(1)) begin
          count[v] <= '0;
        end else if (count[v] == divisor[v] - CNT_W'(1)) begin
          count[v] <= '0;
        end else begin
          count[v] <= count[v] + CNT_W'(1);
        end
      end
    end
  end

  // Presentation muxes read the registers, so a write in the current slot
  // only becomes visible at that voice's next presentation.
  always_comb begin
    bus.ws_count   = count[slot_o];
    bus.ws_divisor = divisor[slot_o];
    bus.ws_mode    = mode[slot_o];
    add            = en[slot_o] ? MIX_W'(bus.ws_sample) : '0;
  end

  always_ff @(posedge clk or negedge Rst_i) begin
    if (!Rst_i) begin
      slot_o      <= '0;
      acc         <= '0;
      mix_o       <= '0;
      mix_valid_o <= 1'b0;
    end else begin
      slot_o <= slot_o + SW'(1);
      if (slot_o == LAST) begin
        mix_o       <= acc + add;
        acc         <= '0;
        mix_valid_o <= 1'b1;
      end else begin
        acc         <= acc + add;
        mix_valid_o <= 1'b0;
      end
    end
  end
endmodule
